frame_scrambler: RTL

Parametrised 802.11a frame scrambler, the next generation of the single-bit scrambler in the transmit path. Processes DATA_WIDTH bits per clock with valid/ready handshakes on both sides. A per-frame seed is loaded on Start, a bit counter bounds the frame, and the six tail bits are forced to zero after scrambling. Sits between the PLCP data assembler and the convolutional encoder.

---
 rtl/frame_scrambler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/frame_scrambler.sv
// 802.11a frame scrambler (x^7+x^4+1), DATA_WIDTH bits per beat, valid/ready on both sides.
// Optional build macro SCRAMBLER_BYPASS_EN adds a per-frame bypass_i input.
module frame_scrambler #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter logic [6:0]  DEFAULT_SEED = 7'h5D
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [6:0]            seed_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic                  bypass_i,
`endif
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [6:0]            lfsr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  bypass_s;

  logic [6:0]            lfsr_d;
  logic [DATA_WIDTH-1:0] beat_d;
  logic [LEN_WIDTH-1:0]  rem_d;
  logic                  xfer_s;

  // rem is the number of frame bits still to come at the start of this beat,
  // so bit k of the beat lies in the six-bit tail when rem <= k + 6.
  function automatic logic [DATA_WIDTH+6:0] scramble_beat(
    input logic [6:0]            s_in,
    input logic [DATA_WIDTH-1:0] d_in,
    input logic [LEN_WIDTH-1:0]  rem,
    input logic                  byp
  );
    logic [6:0]            s;
    logic [DATA_WIDTH-1:0] d;
    logic                  f;
    s = s_in;
    d = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      f = s[6] ^ s[3];
      if (byp) begin
        d[k] = d_in[k];
      end else begin
        d[k] = d_in[k] ^ f;
        s    = {s[5:0], f};
      end
      d[k] = (rem <= LEN_WIDTH'(k + 6)) ? 1'b0 : d[k];
    end
    return {s, d};
  endfunction

`ifdef SCRAMBLER_BYPASS_EN
  logic bypass_q;
  assign bypass_s = bypass_q;
`else
  assign bypass_s = 1'b0;
`endif

  // Next beat datapath: unrolled LFSR, tail masking and saturating bit counter
  always_comb begin
    {lfsr_d, beat_d} = scramble_beat(lfsr_q, in_data_i, rem_q, bypass_s);
    if (rem_q > LEN_WIDTH'(DATA_WIDTH)) begin
      rem_d = rem_q - LEN_WIDTH'(DATA_WIDTH);
    end else begin
      rem_d = '0;
    end
  end

  assign in_ready_o = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
  assign xfer_s     = in_valid_i && in_ready_o;

  // Frame control FSM with registered beat, busy and done outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= DEFAULT_SEED;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            lfsr_q   <= (seed_i == 7'd0) ? DEFAULT_SEED : seed_i;
            rem_q    <= length_i;
            busy_q   <= 1'b1;
`ifdef SCRAMBLER_BYPASS_EN
            bypass_q <= bypass_i;
`endif
            if (length_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            out_data_q  <= beat_d;
            out_valid_q <= 1'b1;
            lfsr_q      <= lfsr_d;
            rem_q       <= rem_d;
            if (rem_d == '0) begin
              state_q <= ST_FLUSH;
            end else begin
              state_q <= ST_RUN;
            end
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= out_valid_q;
          end
        end
        ST_FLUSH: begin
          if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
